// File: rtl/dsi_link_sequencer.sv
// DSI link sequencer: brings the clock lane, data lanes and streaming up and
// down in a fixed order, with per-phase timeouts and a sticky error flag.
module dsi_link_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 link_up_req,
  input  logic [2:0]           lines_number_cfg,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 clock_ready,
  input  logic                 lines_ready,
  input  logic                 lines_active,
  output logic                 clock_enable,
  output logic                 lines_enable,
  output logic [2:0]           lines_number,
  output logic                 streaming_enable,
  output logic                 link_up,
  output logic                 link_error,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CLK_ON    = 4'd1,
    LANES_ON  = 4'd2,
    SETTLE    = 4'd3,
    RUN       = 4'd4,
    DRAIN     = 4'd5,
    LANES_OFF = 4'd6,
    CLK_OFF   = 4'd7,
    ERROR     = 4'd8
  } state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_ONE     = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 clock_enable_d;
  logic                 lines_enable_d;
  logic [2:0]           lines_number_d;
  logic                 streaming_enable_d;
  logic                 link_up_d;
  logic                 link_error_d;
  logic                 cfg_valid;
  logic                 timeout_hit;

  assign cfg_valid   = (lines_number_cfg >= 3'd1) && (lines_number_cfg <= 3'd4);
  assign timeout_hit = (timeout_cycles != '0) && (cnt_q == (timeout_cycles - CNT_ONE));
  assign state_o     = state_q;

  // State register; reset drops straight back to IDLE with no orderly shutdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase counter restarts on every state change and sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Next-state and next-output decode; outputs change on the edge entering a state
  always_comb begin
    state_d            = state_q;
    clock_enable_d     = clock_enable;
    lines_enable_d     = lines_enable;
    lines_number_d     = lines_number;
    streaming_enable_d = streaming_enable;
    link_up_d          = link_up;
    link_error_d       = link_error;

    case (state_q)
      IDLE: begin
        if (link_up_req) begin
          if (cfg_valid) begin
            lines_number_d = lines_number_cfg;
            clock_enable_d = 1'b1;
            state_d        = CLK_ON;
          end else begin
            state_d = ERROR;
          end
        end
      end
      CLK_ON: begin
        if (!link_up_req) begin
          lines_enable_d = 1'b0;
          state_d        = LANES_OFF;
        end else if (clock_ready) begin
          lines_enable_d = 1'b1;
          state_d        = LANES_ON;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end
      end
      LANES_ON: begin
        if (!link_up_req) begin
          lines_enable_d = 1'b0;
          state_d        = LANES_OFF;
        end else if (lines_ready) begin
          state_d = SETTLE;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end
      end
      SETTLE: begin
        if (!link_up_req) begin
          lines_enable_d = 1'b0;
          state_d        = LANES_OFF;
        end else if (cnt_q == SETTLE_LAST) begin
          streaming_enable_d = 1'b1;
          link_up_d          = 1'b1;
          state_d            = RUN;
        end
      end
      RUN: begin
        if (!clock_ready || !lines_ready) begin
          state_d = ERROR;
        end else if (!link_up_req) begin
          streaming_enable_d = 1'b0;
          link_up_d          = 1'b0;
          state_d            = DRAIN;
        end
      end
      DRAIN: begin
        if (!lines_active) begin
          lines_enable_d = 1'b0;
          state_d        = LANES_OFF;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end
      end
      LANES_OFF: begin
        if (!lines_ready) begin
          clock_enable_d = 1'b0;
          state_d        = CLK_OFF;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end
      end
      CLK_OFF: begin
        if (!clock_ready) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        if (!link_up_req) begin
          link_error_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == ERROR) && (state_q != ERROR)) begin
      clock_enable_d     = 1'b0;
      lines_enable_d     = 1'b0;
      streaming_enable_d = 1'b0;
      link_up_d          = 1'b0;
      link_error_d       = 1'b1;
    end
  end

  // Registered outputs toward the core and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clock_enable     <= 1'b0;
      lines_enable     <= 1'b0;
      lines_number     <= 3'd0;
      streaming_enable <= 1'b0;
      link_up          <= 1'b0;
      link_error       <= 1'b0;
    end else begin
      clock_enable     <= clock_enable_d;
      lines_enable     <= lines_enable_d;
      lines_number     <= lines_number_d;
      streaming_enable <= streaming_enable_d;
      link_up          <= link_up_d;
      link_error       <= link_error_d;
    end
  end

endmodule
